// File: rtl/piso_serializer_pkg.sv
// rtl/piso_serializer_pkg.sv - shared types and constants for the PISO serializer
package piso_serializer_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    // Bit-counter width; a 2-bit word still needs one counter bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// rtl/piso_serializer_bit_counter.sv - mod-N bit counter with clear, enable and terminal count
module piso_serializer_bit_counter
    import piso_serializer_pkg::*;
#(
    parameter int MODULUS = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tc
);

    localparam int CW = cnt_width(MODULUS);

    logic [CW-1:0] count;

    // Explicit wrap at MODULUS-1 so non-power-of-2 widths count correctly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            if (tc) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign tc = (count == CW'(MODULUS - 1));

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out stage with one-word holding buffer
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int   WIDTH      = DEFAULT_WIDTH,
    parameter bit   LSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             op,
    output logic             op_valid,
    output logic             frame_start,
    output logic             busy
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] hold_data;
    logic             hold_full;
    logic             hold_next;

    logic             tc;
    logic             accept;
    logic             last_bit;
    logic             load_hold;
    logic             load_in;
    logic             park_in;
    logic             load;
    logic             advance;
    logic [WIDTH-1:0] load_word;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] shreg_shifted;

    // Ready depends only on the holding buffer, never on in_valid.
    assign in_ready = !hold_full;

    piso_serializer_bit_counter #(
        .MODULUS (WIDTH)
    ) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .clear (load),
        .en    (advance),
        .tc    (tc)
    );

    // Decide this edge's action: load a new frame, park a word, advance, or go idle.
    always_comb begin
        accept     = in_valid && in_ready;
        last_bit   = (state == S_SHIFT) && tc;
        load_hold  = last_bit && hold_full;
        load_in    = accept && ((state == S_IDLE) || (last_bit && !hold_full));
        park_in    = accept && (state == S_SHIFT) && !last_bit;
        load       = load_hold || load_in;
        advance    = (state == S_SHIFT) && !load;
        load_word  = load_hold ? hold_data : in_data;

        state_next = state;
        if (load) begin
            state_next = S_SHIFT;
        end else if (last_bit) begin
            state_next = S_IDLE;
        end

        hold_next = hold_full;
        if (park_in) begin
            hold_next = 1'b1;
        end else if (load_hold) begin
            hold_next = 1'b0;
        end
    end

    // Bit-order selection: which bit leads a frame and which follows on each shift.
    always_comb begin
        first_bit     = LSB_FIRST ? load_word[0] : load_word[WIDTH-1];
        next_bit      = LSB_FIRST ? shreg[1] : shreg[WIDTH-2];
        shreg_shifted = LSB_FIRST ? (shreg >> 1) : (shreg << 1);
    end

    // FSM, shifter, holding buffer and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            shreg       <= '0;
            hold_data   <= '0;
            hold_full   <= 1'b0;
            op          <= IDLE_LEVEL;
            op_valid    <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state     <= state_next;
            hold_full <= hold_next;
            busy      <= (state_next == S_SHIFT) || hold_next;

            if (park_in) begin
                hold_data <= in_data;
            end

            if (load) begin
                shreg       <= load_word;
                op          <= first_bit;
                op_valid    <= 1'b1;
                frame_start <= 1'b1;
            end else if (advance && !last_bit) begin
                shreg       <= shreg_shifted;
                op          <= next_bit;
                op_valid    <= 1'b1;
                frame_start <= 1'b0;
            end else begin
                op          <= IDLE_LEVEL;
                op_valid    <= 1'b0;
                frame_start <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - self-checking bench for piso_serializer
`timescale 1ns/1ps
module tb_piso_serializer;
    import piso_serializer_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] in_data = 4'b0000;
    logic       in_valid = 1'b0;

    logic in_ready_l, op_l, op_valid_l, fs_l, busy_l;
    logic in_ready_m, op_m, op_valid_m, fs_m, busy_m;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [1:0] q_l[$];
    logic [1:0] q_m[$];
    logic [1:0] e_l;
    logic [1:0] e_m;
    logic [3:0] chain;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_l), .op(op_l), .op_valid(op_valid_l),
        .frame_start(fs_l), .busy(busy_l)
    );

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_msb (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_m), .op(op_m), .op_valid(op_valid_m),
        .frame_start(fs_m), .busy(busy_m)
    );

    // Downstream 4-bit serial chain fed by the MSB-first instance.
    always @(posedge clk or posedge reset) begin
        if (reset) chain <= 4'b0000;
        else       chain <= {chain[2:0], op_m};
    end

    // Scoreboard: every frame bit popped in order, idle cycles must show IDLE_LEVEL.
    always @(negedge clk) begin
        if (!reset) begin
            n_cmp++;
            if (op_valid_l) begin
                if (q_l.size() == 0) begin
                    n_bad++;
                    $display("FAIL lsb_unexpected_bit: op=%0b fs=%0b, required no frame bit", op_l, fs_l);
                end else begin
                    e_l = q_l.pop_front();
                    if ({op_l, fs_l} !== e_l) begin
                        n_bad++;
                        $display("FAIL lsb_bit: {op,fs}=%b required %b at cyc %0d", {op_l, fs_l}, e_l, cyc);
                    end
                end
            end else if (op_l !== 1'b0 || fs_l !== 1'b0) begin
                n_bad++;
                $display("FAIL lsb_idle: op=%0b fs=%0b required 0/0 at cyc %0d", op_l, fs_l, cyc);
            end
            n_cmp++;
            if (op_valid_m) begin
                if (q_m.size() == 0) begin
                    n_bad++;
                    $display("FAIL msb_unexpected_bit: op=%0b fs=%0b, required no frame bit", op_m, fs_m);
                end else begin
                    e_m = q_m.pop_front();
                    if ({op_m, fs_m} !== e_m) begin
                        n_bad++;
                        $display("FAIL msb_bit: {op,fs}=%b required %b at cyc %0d", {op_m, fs_m}, e_m, cyc);
                    end
                end
            end else if (op_m !== 1'b0 || fs_m !== 1'b0) begin
                n_bad++;
                $display("FAIL msb_idle: op=%0b fs=%0b required 0/0 at cyc %0d", op_m, fs_m, cyc);
            end
        end
    end

    // Offer a word until accepted; expected bits are queued at the accepting edge.
    task automatic send_word(input logic [3:0] w, output int acc, output int stalls);
        bit got;
        got = 1'b0;
        stalls = 0;
        acc = -1;
        in_data = w;
        in_valid = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (in_ready_l) begin
                got = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    q_l.push_back({w[i], logic'(i == 0)});
                    q_m.push_back({w[3-i], logic'(i == 0)});
                end
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: word %b not accepted within 20 cycles", w);
        end else begin
            acc = cyc;
        end
    endtask

    task automatic test_reset();
        #2;
        n_cmp += 5;
        if (op_l !== 1'b0)       begin n_bad++; $display("FAIL reset_op: got %b required 0", op_l); end
        if (op_valid_l !== 1'b0) begin n_bad++; $display("FAIL reset_op_valid: got %b required 0", op_valid_l); end
        if (fs_l !== 1'b0)       begin n_bad++; $display("FAIL reset_frame_start: got %b required 0", fs_l); end
        if (busy_l !== 1'b0)     begin n_bad++; $display("FAIL reset_busy: got %b required 0", busy_l); end
        if (in_ready_l !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b required 1", in_ready_l); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_single_word();
        int a, s;
        send_word(4'b1011, a, s);
        in_valid = 1'b0;
        in_data = 4'b0110;
        for (int r = 1; r <= 6; r++) begin
            @(negedge clk);
            n_cmp += 3;
            if (op_valid_l !== logic'(r <= 4)) begin n_bad++; $display("FAIL single_op_valid: cycle %0d got %b required %b", r, op_valid_l, logic'(r <= 4)); end
            if (fs_l !== logic'(r == 1))       begin n_bad++; $display("FAIL single_frame_start: cycle %0d got %b required %b", r, fs_l, logic'(r == 1)); end
            if (busy_l !== logic'(r <= 4))     begin n_bad++; $display("FAIL single_busy: cycle %0d got %b required %b", r, busy_l, logic'(r <= 4)); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int a1, a2, s1, s2, r;
        send_word(4'b0001, a1, s1);
        send_word(4'b1000, a2, s2);
        in_valid = 1'b0;
        n_cmp++;
        if (a2 !== a1 + 1 || s2 !== 0) begin n_bad++; $display("FAIL b2b_accept: second accept offset %0d stalls %0d required 1 and 0", a2 - a1, s2); end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            r = cyc - a1 + 1;
            n_cmp += 3;
            if (op_valid_l !== logic'(r <= 8))            begin n_bad++; $display("FAIL b2b_op_valid: cycle %0d got %b required %b", r, op_valid_l, logic'(r <= 8)); end
            if (fs_l !== logic'(r == 1 || r == 5))        begin n_bad++; $display("FAIL b2b_frame_start: cycle %0d got %b required %b", r, fs_l, logic'(r == 1 || r == 5)); end
            if (in_ready_l !== logic'(!(r >= 2 && r <= 4))) begin n_bad++; $display("FAIL b2b_in_ready: cycle %0d got %b required %b", r, in_ready_l, logic'(!(r >= 2 && r <= 4))); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        int a1, a2, a3, s1, s2, s3, r;
        send_word(4'b0011, a1, s1);
        send_word(4'b0101, a2, s2);
        send_word(4'b1110, a3, s3);
        in_valid = 1'b0;
        n_cmp += 2;
        if (s3 !== 3)       begin n_bad++; $display("FAIL bp_stalls: third word stalled %0d cycles required 3", s3); end
        if (a3 !== a1 + 5)  begin n_bad++; $display("FAIL bp_accept: third accept offset %0d required 5", a3 - a1); end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            r = cyc - a1 + 1;
            n_cmp += 2;
            if (op_valid_l !== logic'(r <= 12)) begin n_bad++; $display("FAIL bp_op_valid: cycle %0d got %b required %b", r, op_valid_l, logic'(r <= 12)); end
            if (busy_l !== logic'(r <= 12))     begin n_bad++; $display("FAIL bp_busy: cycle %0d got %b required %b", r, busy_l, logic'(r <= 12)); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_frame();
        int a, s;
        send_word(4'b1111, a, s);
        send_word(4'b0110, a, s);
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready_l !== 1'b0) begin n_bad++; $display("FAIL mid_hold_full: in_ready got %b required 0", in_ready_l); end
        #2;
        reset = 1'b1;
        #1;
        q_l.delete();
        q_m.delete();
        n_cmp += 6;
        if (op_l !== 1'b0)       begin n_bad++; $display("FAIL mid_reset_op: got %b required 0", op_l); end
        if (op_valid_l !== 1'b0) begin n_bad++; $display("FAIL mid_reset_op_valid: got %b required 0", op_valid_l); end
        if (busy_l !== 1'b0)     begin n_bad++; $display("FAIL mid_reset_busy: got %b required 0", busy_l); end
        if (in_ready_l !== 1'b1) begin n_bad++; $display("FAIL mid_reset_in_ready: got %b required 1", in_ready_l); end
        if (busy_m !== 1'b0)     begin n_bad++; $display("FAIL mid_reset_busy_msb: got %b required 0", busy_m); end
        if (in_ready_m !== 1'b1) begin n_bad++; $display("FAIL mid_reset_in_ready_msb: got %b required 1", in_ready_m); end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if (op_valid_l !== 1'b0 || busy_l !== 1'b0) begin n_bad++; $display("FAIL mid_no_resume: op_valid=%b busy=%b required 0/0", op_valid_l, busy_l); end
        end
        @(posedge clk);
        #1;
        send_word(4'b0101, a, s);
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_cmp++;
        if (q_l.size() !== 0) begin n_bad++; $display("FAIL mid_after_word: %0d bits outstanding required 0", q_l.size()); end
    endtask

    task automatic test_msb_first();
        int a, s;
        logic [3:0] ec;
        ec = 4'b1100;
        send_word(4'b1100, a, s);
        in_valid = 1'b0;
        for (int r = 1; r <= 9; r++) begin
            @(negedge clk);
            if (r >= 5 && r <= 8) begin
                n_cmp++;
                if (chain[3] !== ec[8-r]) begin n_bad++; $display("FAIL msb_chain: cycle %0d got %b required %b", r, chain[3], ec[8-r]); end
            end else if (r == 9) begin
                n_cmp++;
                if (chain[3] !== 1'b0) begin n_bad++; $display("FAIL msb_chain_idle: got %b required 0", chain[3]); end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_frame();
        test_msb_first();
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (q_l.size() !== 0 || q_m.size() !== 0) begin
            n_bad++;
            $display("FAIL drain: outstanding lsb=%0d msb=%0d required 0/0", q_l.size(), q_m.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
